// File: rtl/func_gen_core.sv
// ============================================================================
//  Module   : func_gen_core
//  Purpose  : Prescaled phase-accumulator waveform engine (saw/tri/square/DC)
//             with a valid/ready config port applied at period boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module func_gen_core #(
    parameter int DAC_W       = 12,
    parameter int PHASE_W     = 24,
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 25
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_i,
    input  logic               en_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [1:0]         cfg_mode_i,
    input  logic [PHASE_W-1:0] cfg_ftw_i,
    input  logic [DAC_W-1:0]   cfg_duty_i,
    input  logic [DIV_W-1:0]   cfg_div_i,
    output logic [DAC_W-1:0]   dac_o,
    output logic               dac_valid_o,
    output logic               sync_o,
    output logic [7:0]         led_o
);

    localparam logic [PHASE_W-1:0] FTW_RST  = {{(DAC_W-1){1'b0}}, 1'b1, {(PHASE_W-DAC_W){1'b0}}};
    localparam logic [DAC_W-1:0]   DUTY_RST = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [DIV_W-1:0]   DIV_RST  = DIV_W'(DIV_DEFAULT);

    // Active configuration
    logic [1:0]         mode_q, mode_d;
    logic [PHASE_W-1:0] ftw_q, ftw_d;
    logic [DAC_W-1:0]   duty_q, duty_d;
    logic [DIV_W-1:0]   div_q, div_d;
    // Shadow configuration waiting for a period boundary
    logic [1:0]         sh_mode_q, sh_mode_d;
    logic [PHASE_W-1:0] sh_ftw_q, sh_ftw_d;
    logic [DAC_W-1:0]   sh_duty_q, sh_duty_d;
    logic [DIV_W-1:0]   sh_div_q, sh_div_d;
    logic               pend_q, pend_d;
    // Datapath state
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [DAC_W-1:0]   dac_q, dac_d;
    logic               dac_valid_q, dac_valid_d;
    logic               sync_q, sync_d;

    logic [PHASE_W:0]   sum_w;
    logic [DAC_W-1:0]   p_w, q_w, wave_w;
    logic               tick_w, apply_w;

    always_comb begin
        sum_w = {1'b0, acc_q} + {1'b0, ftw_q};
        p_w   = acc_q[PHASE_W-1 -: DAC_W];
        q_w   = {p_w[DAC_W-2:0], 1'b0};
        case (mode_q)
            2'd0:    wave_w = p_w;
            2'd1:    wave_w = p_w[DAC_W-1] ? ~q_w : q_w;
            2'd2:    wave_w = (p_w < duty_q) ? {DAC_W{1'b1}} : {DAC_W{1'b0}};
            default: wave_w = duty_q;
        endcase

        tick_w  = en_i && (cnt_q == div_q);
        // Swap configs only where the new one cannot cut a period short
        apply_w = pend_q && (!en_i || (tick_w && sum_w[PHASE_W]));

        mode_d      = mode_q;
        ftw_d       = ftw_q;
        duty_d      = duty_q;
        div_d       = div_q;
        sh_mode_d   = sh_mode_q;
        sh_ftw_d    = sh_ftw_q;
        sh_duty_d   = sh_duty_q;
        sh_div_d    = sh_div_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        dac_d       = dac_q;
        dac_valid_d = 1'b0;
        sync_d      = 1'b0;

        if (en_i) begin
            cnt_d = tick_w ? '0 : cnt_q + DIV_W'(1);
        end
        if (tick_w) begin
            acc_d       = sum_w[PHASE_W-1:0];
            dac_d       = wave_w;
            dac_valid_d = 1'b1;
            sync_d      = sum_w[PHASE_W];
        end

        if (apply_w) begin
            mode_d = sh_mode_q;
            ftw_d  = sh_ftw_q;
            duty_d = sh_duty_q;
            div_d  = sh_div_q;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (cfg_valid_i && !pend_q) begin
            sh_mode_d = cfg_mode_i;
            sh_ftw_d  = cfg_ftw_i;
            sh_duty_d = cfg_duty_i;
            sh_div_d  = cfg_div_i;
            pend_d    = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            mode_q      <= 2'd0;
            ftw_q       <= FTW_RST;
            duty_q      <= DUTY_RST;
            div_q       <= DIV_RST;
            sh_mode_q   <= 2'd0;
            sh_ftw_q    <= '0;
            sh_duty_q   <= '0;
            sh_div_q    <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            dac_q       <= '0;
            dac_valid_q <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            ftw_q       <= ftw_d;
            duty_q      <= duty_d;
            div_q       <= div_d;
            sh_mode_q   <= sh_mode_d;
            sh_ftw_q    <= sh_ftw_d;
            sh_duty_q   <= sh_duty_d;
            sh_div_q    <= sh_div_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            dac_q       <= dac_d;
            dac_valid_q <= dac_valid_d;
            sync_q      <= sync_d;
        end
    end

    assign cfg_ready_o = !pend_q;
    assign dac_o       = dac_q;
    assign dac_valid_o = dac_valid_q;
    assign sync_o      = sync_q;
    assign led_o       = dac_q[DAC_W-1 -: 8];

endmodule

`default_nettype wire

// File: tb/tb_func_gen_core.sv
// ============================================================================
//  Module   : tb_func_gen_core
//  Purpose  : Directed vector bench for func_gen_core (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_func_gen_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_mode = '0;
    logic [23:0] cfg_ftw = '0;
    logic [11:0] cfg_duty = '0;
    logic [7:0]  cfg_div = '0;
    logic [11:0] dac;
    logic        dac_valid;
    logic        sync;
    logic [7:0]  led;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    func_gen_core #(
        .DAC_W(12), .PHASE_W(24), .DIV_W(8), .DIV_DEFAULT(25)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst_n),
        .en_i        (en),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_mode_i  (cfg_mode),
        .cfg_ftw_i   (cfg_ftw),
        .cfg_duty_i  (cfg_duty),
        .cfg_div_i   (cfg_div),
        .dac_o       (dac),
        .dac_valid_o (dac_valid),
        .sync_o      (sync),
        .led_o       (led)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] ftw;
        logic [11:0] duty;
        int          n;
        logic [11:0] exp_dac;
        logic        exp_sync;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_cfg(input logic [1:0] m, input logic [23:0] f,
                            input logic [11:0] d, input logic [7:0] dv);
        cfg_mode  = m;
        cfg_ftw   = f;
        cfg_duty  = d;
        cfg_div   = dv;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_strobe(input int budget, output bit ok, output int edges);
        ok    = 1'b0;
        edges = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (dac_valid) begin
                ok    = 1'b1;
                edges = i;
                return;
            end
        end
    endtask

    // Called at the release negedge with en already high
    task automatic check_defaults(input string tag);
        bit ok;
        int e;
        wait_strobe(60, ok, e);
        chk({tag, "_first_edges"}, e, 26);
        chk({tag, "_first_dac"}, dac, 0);
        chk({tag, "_first_sync"}, sync, 0);
        @(negedge clk);
        chk({tag, "_valid_one_cycle"}, dac_valid, 0);
        wait_strobe(60, ok, e);
        chk({tag, "_second_gap"}, e, 25);
        chk({tag, "_second_dac"}, dac, 1);
        for (int s = 3; s <= 17; s++) begin
            wait_strobe(60, ok, e);
            if (!ok) begin
                chk({tag, "_strobe_timeout"}, 0, 1);
                return;
            end
        end
        chk({tag, "_dac17"}, dac, 16);
        chk({tag, "_led17"}, led, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        int e;
        do_reset();
        send_cfg(v.mode, v.ftw, v.duty, 8'd0);
        en = 1'b1;
        for (int s = 1; s <= v.n; s++) begin
            wait_strobe(4, ok, e);
            if (!ok) begin
                chk($sformatf("v%0d_timeout", idx), 0, 1);
                en = 1'b0;
                return;
            end
        end
        chk($sformatf("v%0d_dac", idx), dac, v.exp_dac);
        chk($sformatf("v%0d_sync", idx), sync, v.exp_sync);
        chk($sformatf("v%0d_led", idx), led, v.exp_dac[11:4]);
        en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int e;
        int s;

        vecs[0]  = '{2'd0, 24'd4096,     12'h800, 1,    12'd0,    1'b0};
        vecs[1]  = '{2'd0, 24'd4096,     12'h800, 4096, 12'd4095, 1'b1};
        vecs[2]  = '{2'd0, 24'd4096,     12'h800, 4097, 12'd0,    1'b0};
        vecs[3]  = '{2'd1, 24'h100000,   12'h800, 2,    12'd512,  1'b0};
        vecs[4]  = '{2'd1, 24'h100000,   12'h800, 8,    12'd3584, 1'b0};
        vecs[5]  = '{2'd1, 24'h100000,   12'h800, 9,    12'd4095, 1'b0};
        vecs[6]  = '{2'd1, 24'h100000,   12'h800, 10,   12'd3583, 1'b0};
        vecs[7]  = '{2'd1, 24'h100000,   12'h800, 16,   12'd511,  1'b1};
        vecs[8]  = '{2'd2, 24'd4096,     12'd1024, 1024, 12'd4095, 1'b0};
        vecs[9]  = '{2'd2, 24'd4096,     12'd1024, 1025, 12'd0,    1'b0};
        vecs[10] = '{2'd2, 24'd4096,     12'd0,   1,    12'd0,    1'b0};
        vecs[11] = '{2'd3, 24'd4096,     12'hABC, 3,    12'hABC,  1'b0};
        vecs[12] = '{2'd0, 24'd0,        12'h800, 5,    12'd0,    1'b0};
        vecs[13] = '{2'd0, 24'h123456,   12'h800, 2,    12'h123,  1'b0};

        // Reset state and default configuration
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dac", dac, 0);
        chk("rst_valid", dac_valid, 0);
        chk("rst_sync", sync, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_led", led, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        check_defaults("dflt");
        en = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Handshake while running: saw 16 samples/period, then switch to DC
        do_reset();
        send_cfg(2'd0, 24'h100000, 12'h800, 8'd0);
        en = 1'b1;
        for (int k = 1; k <= 3; k++) wait_strobe(4, ok, e);
        chk("hs_dac3", dac, 512);
        chk("hs_ready_idle", cfg_ready, 1);
        cfg_mode  = 2'd3;
        cfg_duty  = 12'h123;
        cfg_ftw   = 24'h100000;
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("hs_ready_pending", cfg_ready, 0);
        chk("hs_dac4_old_mode", dac, 768);
        cfg_mode  = 2'd2;
        cfg_duty  = 12'hFFF;
        cfg_div   = 8'd5;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("hs_ready_still_pending", cfg_ready, 0);
        s = 5;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dac_valid) s++;
            if (dac_valid && sync) begin
                ok = 1'b1;
                break;
            end
        end
        chk("hs_sync_seen", ok, 1);
        chk("hs_sync_strobe", s, 16);
        chk("hs_sync_dac_old", dac, 3840);
        chk("hs_ready_back", cfg_ready, 1);
        @(negedge clk);
        chk("hs_new_mode_dac", dac, 12'h123);
        chk("hs_new_mode_sync", sync, 0);
        @(negedge clk);
        chk("hs_second_ignored", dac, 12'h123);
        chk("hs_ready_after", cfg_ready, 1);

        // Asynchronous reset mid-waveform with a config pending
        cfg_mode  = 2'd0;
        cfg_ftw   = 24'h100000;
        cfg_duty  = 12'd0;
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("ar_pending", cfg_ready, 0);
        chk("ar_dac_before", dac, 12'h123);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_dac", dac, 0);
        chk("ar_valid", dac_valid, 0);
        chk("ar_sync", sync, 0);
        chk("ar_led", led, 0);
        chk("ar_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        check_defaults("ar");
        chk("ar_ready_after", cfg_ready, 1);
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
